// File: rtl/fadd_fsub_seq.sv
// Multi-cycle binary32 add/subtract with serial align/normalize, round-to-nearest-even.
// Define FADD_SUBNORMAL_EN for subnormal support; otherwise subnormals flush to zero.
module fadd_fsub_seq #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            rst_n,
    input  logic            En,
    input  logic            Funct,
    input  logic [XLEN-1:0] frs1,
    input  logic [XLEN-1:0] frs2,
    output logic            Busy,
    output logic            Done,
    output logic [XLEN-1:0] frd,
    output logic [4:0]      fflags
);

    typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE} state_t;
    state_t state, state_nx;

    logic [XLEN-1:0] op_a, op_b;   // op_b carries the effective sign
    logic            sa, eff_sub, big;
    logic [9:0]      ex;
    logic [4:0]      cnt;
    logic [26:0]     ma, mb;       // {hidden, frac[22:0], G, R, S}
    logic [27:0]     acc;

    // Unpack: order by magnitude, classify
    logic            a_gt;
    logic [XLEN-1:0] x, y;
    logic [7:0]      exp_x, exp_y, d;
    logic            nan_a, nan_b, snan_a, snan_b, inf_a, inf_b, zero_a, zero_b;
    logic            sp_hit;
    logic [XLEN-1:0] sp_res;
    logic [4:0]      sp_flags;

    assign a_gt  = op_a[30:0] >= op_b[30:0];
    assign x     = a_gt ? op_a : op_b;
    assign y     = a_gt ? op_b : op_a;
    assign exp_x = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
    assign exp_y = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
    assign d     = exp_x - exp_y;

    assign nan_a  = (op_a[30:23] == 8'hFF) && (op_a[22:0] != 23'd0);
    assign nan_b  = (op_b[30:23] == 8'hFF) && (op_b[22:0] != 23'd0);
    assign snan_a = nan_a && !op_a[22];
    assign snan_b = nan_b && !op_b[22];
    assign inf_a  = (op_a[30:23] == 8'hFF) && (op_a[22:0] == 23'd0);
    assign inf_b  = (op_b[30:23] == 8'hFF) && (op_b[22:0] == 23'd0);
`ifdef FADD_SUBNORMAL_EN
    assign zero_a = op_a[30:0] == 31'd0;
    assign zero_b = op_b[30:0] == 31'd0;
`else
    assign zero_a = op_a[30:23] == 8'd0;
    assign zero_b = op_b[30:23] == 8'd0;
`endif

    always_comb begin
        sp_hit   = 1'b1;
        sp_res   = '0;
        sp_flags = 5'b00000;
        if (nan_a || nan_b) begin
            sp_res      = 32'h7FC0_0000;
            sp_flags[4] = snan_a | snan_b;
        end else if (inf_a && inf_b) begin
            if (op_a[31] != op_b[31]) begin
                sp_res   = 32'h7FC0_0000;
                sp_flags = 5'b10000;
            end else sp_res = op_a;
        end else if (inf_a)             sp_res = op_a;
        else if (inf_b)                 sp_res = op_b;
        else if (zero_a && zero_b)      sp_res = {op_a[31] & op_b[31], 31'd0};
        else if (zero_a)                sp_res = op_b;
        else if (zero_b)                sp_res = op_a;
        else                            sp_hit = 1'b0;
    end

    logic [27:0] sum;
    logic        norm_ok, norm_last;
    assign sum       = eff_sub ? ({1'b0, ma} - {1'b0, mb}) : ({1'b0, ma} + {1'b0, mb});
    assign norm_ok   = acc[26] || (ex == 10'd1);
    assign norm_last = acc[25] || (ex == 10'd2);

    // Round to nearest even on {G,R,S}; tininess is judged before rounding
    logic            up, nx, tiny;
    logic [24:0]     rsum;
    logic [9:0]      e_out;
    logic [22:0]     frac;
    logic [XLEN-1:0] rnd_res;
    logic [4:0]      rnd_flags;

    always_comb begin
        nx        = |acc[2:0];
        up        = acc[2] & (acc[1] | acc[0] | acc[3]);
        tiny      = ~acc[26];
        rsum      = {1'b0, acc[26:3]} + {24'd0, up};
        frac      = rsum[24] ? rsum[23:1] : rsum[22:0];
        e_out     = rsum[24] ? ex + 10'd1 : (rsum[23] ? ex : 10'd0);
        rnd_res   = {sa, e_out[7:0], frac};
        rnd_flags = 5'b00000;
        if (e_out >= 10'd255) begin
            rnd_res   = {sa, 8'hFF, 23'd0};
            rnd_flags = 5'b00101;
        end
`ifdef FADD_SUBNORMAL_EN
        else rnd_flags = {3'b000, tiny & nx, nx};
`else
        else if (tiny) begin
            rnd_res   = {sa, 31'd0};
            rnd_flags = 5'b00011;
        end else rnd_flags = {4'b0000, nx};
`endif
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (En) state_nx = UNPACK;
            UNPACK: state_nx = sp_hit ? DONE : ((d == 8'd0) ? ADD : ALIGN);
            ALIGN:  if (big || cnt == 5'd1) state_nx = ADD;
            ADD:    state_nx = (sum == 28'd0) ? DONE : NORM;
            NORM:   if (acc[27] || norm_ok || norm_last) state_nx = ROUND;
            ROUND:  state_nx = DONE;
            DONE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            op_a <= '0; op_b <= '0; sa <= 1'b0; eff_sub <= 1'b0; big <= 1'b0;
            ex <= '0; cnt <= '0; ma <= '0; mb <= '0; acc <= '0;
            frd <= '0; fflags <= '0;
        end else begin
            case (state)
                IDLE: if (En) begin
                    op_a <= frs1;
                    op_b <= {frs2[31] ^ Funct, frs2[30:0]};
                end
                UNPACK: if (sp_hit) begin
                    frd    <= sp_res;
                    fflags <= sp_flags;
                end else begin
                    sa      <= x[31];
                    eff_sub <= x[31] ^ y[31];
                    ex      <= {2'b00, exp_x};
                    ma      <= {|x[30:23], x[22:0], 3'b000};
                    mb      <= {|y[30:23], y[22:0], 3'b000};
                    cnt     <= d[4:0];
                    big     <= d >= 8'd27;
                end
                ALIGN: if (big) mb <= 27'd1;
                else begin
                    mb  <= {1'b0, mb[26:2], mb[1] | mb[0]};
                    cnt <= cnt - 5'd1;
                end
                ADD: if (sum == 28'd0) begin
                    frd    <= '0;
                    fflags <= '0;
                end else acc <= sum;
                NORM: if (acc[27]) begin
                    acc <= {1'b0, acc[27:2], acc[1] | acc[0]};
                    ex  <= ex + 10'd1;
                end else if (!norm_ok) begin
                    acc <= {acc[26:0], 1'b0};
                    ex  <= ex - 10'd1;
                end
                ROUND: begin
                    frd    <= rnd_res;
                    fflags <= rnd_flags;
                end
                default: ;
            endcase
        end
    end

    assign Busy = state != IDLE;
    assign Done = state == DONE;

endmodule
